xalu_ctrl: RTL and testbench

- Sequencer for the pipeline's multiply/divide resource (the XALU).
- Accepts one op per cycle from the E stage and latches the operands.
- Runs a latency counter per op, then commits the result to the HI/LO registers.
- Raises a stall request toward D while any XALU-using instruction (usingXALU from decode) would conflict with an op that is in flight or just starting.

---
 rtl/xalu_pkg.sv | 41 ++++
 rtl/xalu_calc.sv | 72 +++++++
 rtl/xalu_ctrl.sv | 121 ++++++++++++
 tb/tb_xalu_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xalu_pkg.sv
// xalu_pkg: shared definitions for the XALU sequencer.
//   - Op code encodings driven on e_op by the E stage.
//   - Default busy latencies for multiply-class and divide-class ops.
//   - is_xalu_start(): op codes that start a multi-cycle operation.
//   - is_div_op(): op codes that use the divide latency.
// Optional feature macro: XALU_MADD_EN (MADD/MSUB decode as multi-cycle ops).
package xalu_pkg;

   localparam logic [3:0] OpNone  = 4'd0;
   localparam logic [3:0] OpMult  = 4'd1;
   localparam logic [3:0] OpMultu = 4'd2;
   localparam logic [3:0] OpDiv   = 4'd3;
   localparam logic [3:0] OpDivu  = 4'd4;
   localparam logic [3:0] OpMthi  = 4'd5;
   localparam logic [3:0] OpMtlo  = 4'd6;
   localparam logic [3:0] OpMfhi  = 4'd7;
   localparam logic [3:0] OpMflo  = 4'd8;
   localparam logic [3:0] OpMadd  = 4'd9;
   localparam logic [3:0] OpMsub  = 4'd10;

   localparam int unsigned MultLatDefault = 5;
   localparam int unsigned DivLatDefault  = 10;

   function automatic logic is_xalu_start(input logic [3:0] op);
      logic res;
      res = 1'b0;
      case (op)
         OpMult, OpMultu, OpDiv, OpDivu: res = 1'b1;
`ifdef XALU_MADD_EN
         OpMadd, OpMsub:                 res = 1'b1;
`endif
         default:                        res = 1'b0;
      endcase
      return res;
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == OpDiv) || (op == OpDivu);
   endfunction

endpackage

// File: rtl/xalu_calc.sv
// xalu_calc: combinational XALU datapath.
// Ports:
//   op_i       op code (xalu_pkg encoding)
//   a_i, b_i   operands (RS, RT)
//   hi_i, lo_i current HI/LO, used as accumulator for MADD/MSUB
//   res_o      64-bit result {HI, LO}
//   divzero_o  divide op with zero divisor; result must not be committed
// Optional feature macro: XALU_MADD_EN (accumulate datapath present only when defined).
module xalu_calc
   import xalu_pkg::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   output logic [63:0] res_o,
   output logic        divzero_o
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        sgn_div;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] b_safe;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   assign prod_s = {{32{a_i[31]}}, a_i} * {{32{b_i[31]}}, b_i};
   assign prod_u = {32'd0, a_i} * {32'd0, b_i};

   // One unsigned divider serves both DIV and DIVU; DIV divides magnitudes and
   // fixes signs afterwards, which also gives 0x80000000 / -1 = 0x80000000 rem 0.
   assign sgn_div = (op_i == OpDiv);
   assign a_mag   = (sgn_div && a_i[31]) ? (32'd0 - a_i) : a_i;
   assign b_mag   = (sgn_div && b_i[31]) ? (32'd0 - b_i) : b_i;
   assign b_safe  = (b_mag == 32'd0) ? 32'd1 : b_mag;
   assign q_mag   = a_mag / b_safe;
   assign r_mag   = a_mag % b_safe;
   assign quot    = (sgn_div && (a_i[31] ^ b_i[31])) ? (32'd0 - q_mag) : q_mag;
   assign rem     = (sgn_div && a_i[31]) ? (32'd0 - r_mag) : r_mag;

   assign divzero_o = is_div_op(op_i) && (b_i == 32'd0);

   always_comb begin
      res_o = '0;
      case (op_i)
         OpNone:  res_o = '0;
         OpMult:  res_o = prod_s;
         OpMultu: res_o = prod_u;
         OpDiv:   res_o = {rem, quot};
         OpDivu:  res_o = {rem, quot};
`ifdef XALU_MADD_EN
         OpMadd:  res_o = {hi_i, lo_i} + prod_s;
         OpMsub:  res_o = {hi_i, lo_i} - prod_s;
`endif
         default: res_o = '0;
      endcase
   end

`ifndef XALU_MADD_EN
   // Accumulator inputs and MADD/MSUB codes have no function in this build.
   logic [63:0] unused_acc;
   logic        unused_madd;
   assign unused_acc  = {hi_i, lo_i};
   assign unused_madd = (op_i == OpMadd) | (op_i == OpMsub);
`endif

endmodule

// File: rtl/xalu_ctrl.sv
// xalu_ctrl: sequencer for the pipeline's multiply/divide resource.
// Accepts one op per cycle from E; multi-cycle ops latch their result into
// pending registers at start and commit it to HI/LO when the latency counter
// expires. Requests a D-stage stall while an XALU op is in flight or starting.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   e_valid, e_op     E-stage valid and op code
//   e_rs, e_rt        forwarded operands at E
//   d_uses_xalu       instruction in D uses the XALU
//   busy              multi-cycle op in flight
//   stall             stall request to the hazard unit
//   rd_data           HI for MFHI, LO for MFLO, else 0 (combinational)
//   hi, lo            architectural HI/LO
// Parameters MULT_LAT, DIV_LAT: busy cycles per op class (both must be >= 1).
// Optional feature macro: XALU_MADD_EN (enables MADD/MSUB).
module xalu_ctrl
   import xalu_pkg::*;
#(
   parameter int unsigned MULT_LAT = MultLatDefault,
   parameter int unsigned DIV_LAT  = DivLatDefault
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        e_valid,
   input  logic [3:0]  e_op,
   input  logic [31:0] e_rs,
   input  logic [31:0] e_rt,
   input  logic        d_uses_xalu,
   output logic        busy,
   output logic        stall,
   output logic [31:0] rd_data,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MaxLat = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int unsigned CntW   = $clog2(MaxLat + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [31:0]     pend_hi_q, pend_hi_d;
   logic [31:0]     pend_lo_q, pend_lo_d;
   logic            pend_dz_q, pend_dz_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;

   logic            start;
   logic            accept;
   logic [63:0]     calc_res;
   logic            calc_dz;

   xalu_calc u_calc (
      .op_i      (e_op),
      .a_i       (e_rs),
      .b_i       (e_rt),
      .hi_i      (hi_q),
      .lo_i      (lo_q),
      .res_o     (calc_res),
      .divzero_o (calc_dz)
   );

   assign busy   = (cnt_q != '0);
   assign accept = e_valid & ~busy;
   assign start  = accept & is_xalu_start(e_op);
   assign stall  = d_uses_xalu & (busy | start);
   assign hi     = hi_q;
   assign lo     = lo_q;

   always_comb begin
      rd_data = '0;
      case (e_op)
         OpMfhi:  rd_data = hi_q;
         OpMflo:  rd_data = lo_q;
         default: rd_data = '0;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_dz_d = pend_dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      if (start) begin
         cnt_d     = is_div_op(e_op) ? CntW'(DIV_LAT) : CntW'(MULT_LAT);
         pend_hi_d = calc_res[63:32];
         pend_lo_d = calc_res[31:0];
         pend_dz_d = calc_dz;
      end else if (busy) begin
         cnt_d = cnt_q - CntW'(1);
         // Last busy cycle: the edge ending it is the commit edge.
         if ((cnt_q == CntW'(1)) && !pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end

      if (accept && (e_op == OpMthi)) hi_d = e_rs;
      if (accept && (e_op == OpMtlo)) lo_d = e_rs;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_dz_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_dz_q <= pend_dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

endmodule

// File: tb/tb_xalu_ctrl.sv
// Bench for xalu_ctrl: directed cases plus randomized ops, checked against a
// reference model using 64-bit integer arithmetic. Commits are checked by a
// monitor that pops expected results whenever busy falls.
module tb_xalu_ctrl;
   import xalu_pkg::*;

   localparam int unsigned MultLat = 5;
   localparam int unsigned DivLat  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        e_valid;
   logic [3:0]  e_op;
   logic [31:0] e_rs;
   logic [31:0] e_rt;
   logic        d_uses_xalu;
   logic        busy;
   logic        stall;
   logic [31:0] rd_data;
   logic [31:0] hi;
   logic [31:0] lo;

   always #5 clk = ~clk;

   xalu_ctrl #(
      .MULT_LAT (MultLat),
      .DIV_LAT  (DivLat)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .e_valid     (e_valid),
      .e_op        (e_op),
      .e_rs        (e_rs),
      .e_rt        (e_rt),
      .d_uses_xalu (d_uses_xalu),
      .busy        (busy),
      .stall       (stall),
      .rd_data     (rd_data),
      .hi          (hi),
      .lo          (lo)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   int          tests = 0;
   int          fails = 0;
   exp_t        sb_q[$];
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   bit          abort_flag = 1'b0;
   bit          prev_busy  = 1'b0;
   int          busy_len   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: which ops run multi-cycle, and their results.
   function automatic bit ref_is_start(input logic [3:0] op);
      bit r;
      r = (op >= 4'd1 && op <= 4'd4);
`ifdef XALU_MADD_EN
      if (op == 4'd9 || op == 4'd10) r = 1'b1;
`endif
      return r;
   endfunction

   function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] h, input logic [31:0] l,
                                  output bit st, output int lat,
                                  output logic [31:0] nh, output logic [31:0] nl);
      longint sa, sb, q, r, p;
      logic [63:0] acc;
      st  = ref_is_start(op);
      lat = (op == OpDiv || op == OpDivu) ? int'(DivLat) : int'(MultLat);
      nh  = h;
      nl  = l;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      p   = sa * sb;
      if (st) begin
         case (op)
            OpMult: {nh, nl} = p;
            OpMultu: {nh, nl} = {32'd0, a} * {32'd0, b};
            OpDiv: if (b != 0) begin
               q  = sa / sb;
               r  = sa % sb;
               nl = q[31:0];
               nh = r[31:0];
            end
            OpDivu: if (b != 0) begin
               nl = a / b;
               nh = a % b;
            end
            OpMadd: begin
               acc = {h, l} + 64'(p);
               {nh, nl} = acc;
            end
            OpMsub: begin
               acc = {h, l} - 64'(p);
               {nh, nl} = acc;
            end
            default: ;
         endcase
      end
   endfunction

   function automatic logic [31:0] rd_exp(input logic [3:0] op);
      if (op == OpMfhi) return m_hi;
      if (op == OpMflo) return m_lo;
      return 32'd0;
   endfunction

   function automatic logic pick_d(input int dmode);
      if (dmode == 1) return 1'b1;
      if (dmode == 2) return 1'b0;
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [31:0] pick_operand();
      logic [31:0] specials [6];
      specials = '{32'h0, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h1, 32'h2};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   // Monitor: every busy fall is a commit (or an abort by reset).
   always @(negedge clk) begin
      exp_t e;
      if (prev_busy && busy === 1'b0) begin
         if (abort_flag) begin
            abort_flag = 1'b0;
         end else if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_commit: got busy fall expected none (t=%0t)", $time);
         end else begin
            e = sb_q.pop_front();
            check("commit_hi", hi, e.hi);
            check("commit_lo", lo, e.lo);
            check("busy_len", busy_len, e.lat);
         end
         busy_len = 0;
      end
      if (busy === 1'b1) busy_len++;
      prev_busy = (busy === 1'b1);
   end

   // Issue one op in a non-busy cycle; for multi-cycle ops, spend the busy
   // window driving junk that the DUT must ignore.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int dmode);
      bit          st;
      int          lat;
      logic [31:0] nh, nl;
      logic        d;
      exp_t        e;
      @(posedge clk);
      #1;
      d           = pick_d(dmode);
      e_valid     = 1'b1;
      e_op        = op;
      e_rs        = a;
      e_rt        = b;
      d_uses_xalu = d;
      ref_op(op, a, b, m_hi, m_lo, st, lat, nh, nl);
      if (st) begin
         e.hi  = nh;
         e.lo  = nl;
         e.lat = lat;
         sb_q.push_back(e);
      end
      @(negedge clk);
      check("issue_busy", busy, 1'b0);
      check("issue_hi", hi, m_hi);
      check("issue_lo", lo, m_lo);
      check("issue_stall", stall, d & st);
      check("issue_rd", rd_data, rd_exp(op));
      if (st) begin
         for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            d           = pick_d(dmode);
            e_valid     = 1'($urandom_range(0, 1));
            e_op        = 4'($urandom_range(0, 15));
            e_rs        = $urandom;
            e_rt        = $urandom;
            d_uses_xalu = d;
            @(negedge clk);
            check("win_busy", busy, 1'b1);
            check("win_stall", stall, d);
            check("win_rd", rd_data, rd_exp(e_op));
            check("win_hi", hi, m_hi);
            check("win_lo", lo, m_lo);
         end
         m_hi = nh;
         m_lo = nl;
      end else if (op == OpMthi) begin
         m_hi = a;
      end else if (op == OpMtlo) begin
         m_lo = a;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         e_valid     = 1'b0;
         e_op        = OpNone;
         d_uses_xalu = 1'b1;
         @(negedge clk);
         check("idle_busy", busy, 1'b0);
         check("idle_stall", stall, 1'b0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset       = 1'b1;
      e_valid     = 1'b0;
      e_op        = OpNone;
      e_rs        = '0;
      e_rt        = '0;
      d_uses_xalu = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_stall", stall, 1'b0);

      // Multiply with stall forced on, then without.
      run_op(OpMult, 32'hFFFFFFFE, 32'd3, 1);
      idle(1);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFFA);
      run_op(OpMultu, 32'hFFFFFFFE, 32'd3, 2);
      idle(1);
      check("multu_hi", hi, 32'h00000002);
      check("multu_lo", lo, 32'hFFFFFFFA);

      // Divide, divide by zero, signed overflow case.
      run_op(OpDiv, 32'hFFFFFFF9, 32'd2, 0);
      idle(1);
      check("div_hi", hi, 32'hFFFFFFFF);
      check("div_lo", lo, 32'hFFFFFFFD);
      run_op(OpDiv, 32'd55, 32'd0, 0);
      idle(1);
      check("divz_hi", hi, 32'hFFFFFFFF);
      check("divz_lo", lo, 32'hFFFFFFFD);
      run_op(OpDiv, 32'h80000000, 32'hFFFFFFFF, 0);
      idle(1);
      check("divovf_hi", hi, 32'h00000000);
      check("divovf_lo", lo, 32'h80000000);

      // Move to/from HI.
      run_op(OpMthi, 32'h00001234, 32'd0, 0);
      run_op(OpMfhi, 32'd0, 32'd0, 0);
      check("mfhi_rd", rd_data, 32'h00001234);

      // Accumulate: with the feature, 1*1 carries into HI; without, a no-op.
      run_op(OpMthi, 32'd0, 32'd0, 0);
      run_op(OpMtlo, 32'hFFFFFFFF, 32'd0, 0);
      run_op(OpMadd, 32'd1, 32'd1, 1);
      idle(1);
`ifdef XALU_MADD_EN
      check("madd_hi", hi, 32'd1);
      check("madd_lo", lo, 32'd0);
`else
      check("madd_hi", hi, 32'd0);
      check("madd_lo", lo, 32'hFFFFFFFF);
`endif

      // Reset during a divide abandons it.
      run_op(OpMthi, 32'hABCD0000, 32'd0, 0);
      @(posedge clk);
      #1;
      e_valid     = 1'b1;
      e_op        = OpDiv;
      e_rs        = 32'd100;
      e_rt        = 32'd7;
      d_uses_xalu = 1'b0;
      @(posedge clk);
      #1;
      e_valid = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset      = 1'b1;
      abort_flag = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      @(negedge clk);
      check("abort_busy", busy, 1'b0);
      check("abort_hi", hi, 32'd0);
      check("abort_lo", lo, 32'd0);
      idle(15);
      check("abort_late_hi", hi, 32'd0);
      check("abort_late_lo", lo, 32'd0);

      // Randomized ops.
      for (int i = 0; i < 150; i++) begin
         run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), 0);
      end
      idle(3);
      check("sb_empty", sb_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
